scale_arbiter: RTL and testbench
================================

# scale_arbiter

Round-robin arbiter that shares one `scale` unit (3-vector × Q-format scalar) among `N_REQ` requester FIFOs. It pops one request at a time from the winning requester, holds it for the shared unit, and records the requester ID in an order (tag) FIFO. It then steers each result popped from the unit's output FIFO back to the originating requester's response FIFO. It sits between several geometry stages, such as per-ray normal and direction scaling, and a single multiplier-heavy `scale` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TAG_DEPTH`, 8: max requests in flight inside the shared unit; power of 2.
- `ID_W`, `$clog2(N_REQ)`: tag width (derived).
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_x` in `N_REQ`×3×32 signed: per-requester vector, FWFT FIFO data.
- `req_a` in `N_REQ`×32 signed: per-requester scalar.
- `req_empty` in `N_REQ`: requester FIFO empty.
- `req_rd_en` out `N_REQ`: one-hot pop of the granted requester.
- `su_x` out 3×32 signed: vector presented to the shared unit.
- `su_a` out 32 signed: scalar presented to the shared unit.
- `su_in_empty` out 1: low while the hold register contains a request.
- `su_in_rd_en` in 1: the shared unit consumes the held request.
- `su_out` in 3×32 signed: shared unit result, FWFT.
- `su_out_empty` in 1: shared unit output FIFO empty.
- `su_out_rd_en` out 1: pop one result.
- `rsp_out` out 3×32 signed: result broadcast to all response FIFOs.
- `rsp_wr_en` out `N_REQ`: one-hot write into the originating requester's response FIFO.
- `rsp_full` in `N_REQ`: response FIFO full.
- `inflight` out `$clog2(TAG_DEPTH)+1`: tag FIFO occupancy.

## Operation
- **Issue FSM**: two states, `IDLE` and `LOADED`.
  - `IDLE`: if any `req_empty[i]==0` and the tag FIFO is not full:
    - select the winner g = first non-empty index after `rr_ptr`, cyclic;
    - assert `req_rd_en[g]` combinationally;
    - latch `req_x[g]`, `req_a[g]` into the hold register, latch g into `hold_id`;
    - set `rr_ptr <= g`; go to `LOADED`.
  - `LOADED`: `su_in_empty=0`, `su_x`/`su_a` driven from the hold register. When `su_in_rd_en==1`, push `hold_id` into the tag FIFO and go to `IDLE`.
- **Fairness**: the `rr_ptr` reset value is `N_REQ-1`, so requester 0 wins first. A requester that has just been served has the lowest priority on the next arbitration.
- **Return path**: purely combinational.
  - Let h = tag FIFO head.
  - `ret_ok = !su_out_empty && !tag_empty && !rsp_full[h]`.
  - When `ret_ok` is true: `su_out_rd_en=1`, `rsp_wr_en[h]=1`, tag pop.
  - `rsp_out = su_out` at all times; it is only qualified by `rsp_wr_en`.
- **Ordering**: results return in issue order. A full `rsp_full[h]` blocks all returns (head-of-line). This is accepted behaviour.
- **Simultaneous tag push and pop**: both are performed and occupancy is unchanged. Push is never blocked by a same-cycle pop, because the full check happened at issue time.
- **Guard conditions**:
  - A tag FIFO with no entry, combined with `su_out_empty==0`, is a protocol error. The block does not pop in this case; the bench asserts it never happens.
  - The block never asserts `su_out_rd_en` while `su_out_empty==1`.
  - The block never asserts `req_rd_en[i]` while `req_empty[i]==1`.
- **No arithmetic here**: Q scaling is done by the shared unit. Data passes through the arbiter unmodified and sign-preserved.

## Timing
- **Reset values**:
  - state `IDLE`; `rr_ptr = N_REQ-1`; tag FIFO empty; `inflight=0`;
  - hold register = 0, so `su_x`/`su_a` read 0;
  - `su_in_empty=1`; `req_rd_en`, `su_out_rd_en`, `rsp_wr_en` = 0 while `reset` is high.
- **Issue latency**: `req_empty` falls at cycle 0 → `req_rd_en` at cycle 0 (if `IDLE`) → `su_in_empty` low at cycle 1.
- **Issue throughput**: at most 1 request per 2 cycles.
- **Return latency**: 0 cycles added; `rsp_wr_en` is in the same cycle that the result is visible and unblocked.
- **Reset mid-operation**: hold register contents and all tags are discarded. The shared `scale` unit and all FIFOs share `reset`, so no orphan results remain.
- **Back-pressure**: issue stalls when `inflight==TAG_DEPTH`. While stalled, `req_rd_en` stays 0 and the state stays `IDLE`.

## Structure
- **Package `scale_arb_pkg`**: `issue_state_t` enum (`IDLE`, `LOADED`); `vec3_t` typedef (3×32 signed); `rr_pick` function (one-hot winner from request mask and pointer).
- **Sub-module `tag_fifo`**: synchronous FIFO, width `ID_W`, depth `TAG_DEPTH`, FWFT head, `count` output. It drives `inflight`.
- **Top `scale_arbiter`**: contains the issue FSM, hold register, and return steering.

## Test plan
- **Single request**, with `scale` Q_BITS=10 as DUT partner: requester 2 sends x=(1024,2048,-1024), a=1536. Expect `rsp_wr_en=4'b0100` with `rsp_out=(1536,3072,-1536)`, and `inflight` back to 0.
- **Round-robin**: all 4 requesters always non-empty. Expect grant order 0,1,2,3,0,1 and `req_rd_en` one-hot every 2 cycles, with no stalls.
- **Return back-pressure**: tag head=1 and `rsp_full[1]=1` for 10 cycles. Expect `su_out_rd_en=0` and no `rsp_wr_en` for those 10 cycles. After release, write to requester 1 first, then the remaining results in issue order.
- **Tag full**: with `TAG_DEPTH=4`, hold `su_out_empty=1`. After 4 issues, `inflight=4`, and `req_rd_en` stays 0 despite pending requests. The first return re-enables issue in the next cycle.
- **Simultaneous push/pop**: issue completion and result return in the same cycle. Expect `inflight` unchanged and tags ordered correctly.
- **Reset mid-operation**: assert `reset` for 1 cycle while in `LOADED` with `inflight=3`. Expect `su_in_empty=1`, `inflight=0`, and the next grant goes to requester 0.

Source files
------------

// File: rtl/scale_arb_pkg.sv
// Shared types and the round-robin pick helper for the scale arbiter slice.
package scale_arb_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned MAX_REQ  = 8;
   localparam int unsigned MAX_ID_W = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      LOADED = 1'b1
   } issue_state_t;

   typedef logic signed [WORD_W-1:0] word_t;
   typedef word_t [2:0] vec3_t;

   // One-hot winner: first set bit of req strictly after ptr, wrapping modulo n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int unsigned n);
      logic        found;
      int unsigned idx;
      rr_pick = '0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         idx = (32'(ptr) + k) % n;
         if (k <= n && !found && req[MAX_ID_W'(idx)]) begin
            rr_pick[MAX_ID_W'(idx)] = 1'b1;
            found = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/scale_arbiter_if.sv
// Requester, shared-unit and response signals of the scale arbiter.
interface scale_arbiter_if
   import scale_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned TAG_DEPTH = 8
);
   localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

   vec3_t [N_REQ-1:0] req_x;
   word_t [N_REQ-1:0] req_a;
   logic  [N_REQ-1:0] req_empty;
   logic  [N_REQ-1:0] req_rd_en;
   vec3_t             su_x;
   word_t             su_a;
   logic              su_in_empty;
   logic              su_in_rd_en;
   vec3_t             su_out;
   logic              su_out_empty;
   logic              su_out_rd_en;
   vec3_t             rsp_out;
   logic  [N_REQ-1:0] rsp_wr_en;
   logic  [N_REQ-1:0] rsp_full;
   logic  [CNT_W-1:0] inflight;

   modport master (
      input  req_x, req_a, req_empty, su_in_rd_en, su_out, su_out_empty, rsp_full,
      output req_rd_en, su_x, su_a, su_in_empty, su_out_rd_en, rsp_out, rsp_wr_en, inflight
   );

   modport slave (
      output req_x, req_a, req_empty, su_in_rd_en, su_out, su_out_empty, rsp_full,
      input  req_rd_en, su_x, su_a, su_in_empty, su_out_rd_en, rsp_out, rsp_wr_en, inflight
   );

endinterface

// File: rtl/scale_arbiter_tag_fifo.sv
// Order FIFO of requester IDs for requests in flight in the shared unit; FWFT head.
module tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty_c = (count == '0);
      full_c  = (count == CNT_W'(DEPTH));
      dout_c  = mem[rd_ptr];
      do_pop  = pop && !empty_c;
      do_push = push && (!full_c || do_pop);
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/scale_arbiter.sv
// Round-robin sharing of one scale unit among N_REQ requesters, with in-order
// steering of results back to the originating requester via a tag FIFO.
module scale_arbiter
   import scale_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic            clock,
   input  logic            reset,
   scale_arbiter_if.master bus
);
   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

   issue_state_t     state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  hold_id;
   vec3_t            hold_x;
   word_t            hold_a;

   logic [MAX_REQ-1:0] pick8;
   logic               unused_pick;
   logic [N_REQ-1:0]   grant_oh;
   logic [ID_W-1:0]    grant_id;
   logic               issue;
   logic               push;
   logic               ret_ok;
   logic [ID_W-1:0]    head_id;
   logic               tag_full;
   logic               tag_empty;
   logic [CNT_W-1:0]   tag_count;

   // Arbitration, issue handshake and combinational return steering.
   always_comb begin
      pick8       = rr_pick(MAX_REQ'(~bus.req_empty), MAX_ID_W'(rr_ptr), N_REQ);
      unused_pick = ^pick8;
      grant_oh    = pick8[N_REQ-1:0];
      grant_id    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_oh[i]) grant_id = ID_W'(i);
      end

      issue = !reset && (state == IDLE) && (|(~bus.req_empty)) && !tag_full;
      push  = !reset && (state == LOADED) && bus.su_in_rd_en;

      bus.req_rd_en   = issue ? grant_oh : '0;
      bus.su_in_empty = (state != LOADED);
      bus.su_x        = hold_x;
      bus.su_a        = hold_a;

      ret_ok           = !reset && !bus.su_out_empty && !tag_empty && !bus.rsp_full[head_id];
      bus.su_out_rd_en = ret_ok;
      bus.rsp_wr_en    = ret_ok ? (N_REQ'(1) << head_id) : '0;
      bus.rsp_out      = bus.su_out;
      bus.inflight     = tag_count;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         rr_ptr  <= ID_W'(N_REQ - 1);
         hold_id <= '0;
         hold_x  <= '0;
         hold_a  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  hold_x  <= bus.req_x[grant_id];
                  hold_a  <= bus.req_a[grant_id];
                  hold_id <= grant_id;
                  rr_ptr  <= grant_id;
                  state   <= LOADED;
               end
            end
            LOADED: begin
               if (bus.su_in_rd_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   tag_fifo #(
      .WIDTH (ID_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .din     (hold_id),
      .pop     (ret_ok),
      .dout_c  (head_id),
      .full_c  (tag_full),
      .empty_c (tag_empty),
      .count   (tag_count)
   );

endmodule

// File: tb/tb_scale_arbiter.sv
// Directed bench for scale_arbiter: issue, round-robin, return back-pressure,
// tag-full stall, simultaneous push/pop and reset mid-operation.
module tb_scale_arbiter;
   import scale_arb_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned TD  = 4;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   scale_arbiter_if #(.N_REQ(N), .TAG_DEPTH(TD)) bus ();

   scale_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec3_t mkv(input int a, input int b, input int c);
      vec3_t v;
      v[0] = a;
      v[1] = b;
      v[2] = c;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // Per-cycle protocol guards, then advance to just after the next rising edge.
   task automatic step();
      #1;
      chk("guard_req_pop", 128'(bus.req_rd_en & bus.req_empty), 128'(0));
      chk("guard_su_pop", 128'(bus.su_out_rd_en & bus.su_out_empty), 128'(0));
      chk("guard_tag_proto", 128'(bus.su_out_empty | (bus.inflight != 0)), 128'(1));
      @(posedge clock);
      #1;
   endtask

   task automatic issue_one(input logic [3:0] nonempty, input logic [3:0] exp_grant);
      bus.req_empty = ~nonempty;
      settle();
      chk("issue_grant", 128'(bus.req_rd_en), 128'(exp_grant));
      step();
      bus.req_empty   = 4'hF;
      bus.su_in_rd_en = 1'b1;
      settle();
      chk("issue_loaded", 128'(bus.su_in_empty), 128'(0));
      step();
      bus.su_in_rd_en = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.req_x        = '0;
      bus.req_a        = '0;
      bus.req_empty    = 4'hF;
      bus.su_in_rd_en  = 1'b0;
      bus.su_out       = '0;
      bus.su_out_empty = 1'b1;
      bus.rsp_full     = 4'h0;
      @(posedge clock);
      #1;

      // Reset state, with pending requests that must not be popped.
      bus.req_empty = 4'h0;
      settle();
      chk("rst_rd_en", 128'(bus.req_rd_en), 128'(0));
      chk("rst_su_in_empty", 128'(bus.su_in_empty), 128'(1));
      chk("rst_inflight", 128'(bus.inflight), 128'(0));
      chk("rst_su_x", 128'(bus.su_x), 128'(0));
      chk("rst_su_a", 128'(bus.su_a), 128'(0));
      bus.req_empty = 4'hF;
      step();
      reset = 1'b0;
      step();

      // Single request from requester 2; partner unit returns x*a with Q10.
      bus.req_x[2]  = mkv(1024, 2048, -1024);
      bus.req_a[2]  = 1536;
      bus.req_empty = 4'b1011;
      settle();
      chk("single_grant", 128'(bus.req_rd_en), 128'(4'b0100));
      step();
      bus.req_empty = 4'hF;
      settle();
      chk("single_su_in_empty", 128'(bus.su_in_empty), 128'(0));
      chk("single_su_x", 128'(bus.su_x), 128'(mkv(1024, 2048, -1024)));
      chk("single_su_a", 128'(bus.su_a), 128'(32'sd1536));
      bus.su_in_rd_en = 1'b1;
      step();
      bus.su_in_rd_en = 1'b0;
      settle();
      chk("single_inflight1", 128'(bus.inflight), 128'(1));
      chk("single_idle", 128'(bus.su_in_empty), 128'(1));
      bus.su_out       = mkv(1536, 3072, -1536);
      bus.su_out_empty = 1'b0;
      settle();
      chk("single_su_out_rd", 128'(bus.su_out_rd_en), 128'(1));
      chk("single_rsp_wr", 128'(bus.rsp_wr_en), 128'(4'b0100));
      chk("single_rsp_out", 128'(bus.rsp_out), 128'(mkv(1536, 3072, -1536)));
      step();
      bus.su_out_empty = 1'b1;
      settle();
      chk("single_inflight0", 128'(bus.inflight), 128'(0));

      // Round-robin with all requesters busy; each result returns while the next issues.
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req_empty = 4'h0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            bus.su_out_empty = 1'b0;
            bus.su_out       = mkv(k, -k, 7 * k);
         end
         settle();
         chk("rr_grant", 128'(bus.req_rd_en), 128'(4'b0001 << (k % 4)));
         if (k > 0) chk("rr_return", 128'(bus.rsp_wr_en), 128'(4'b0001 << ((k - 1) % 4)));
         step();
         bus.su_out_empty = 1'b1;
         bus.su_in_rd_en  = 1'b1;
         settle();
         chk("rr_loaded", 128'({bus.su_in_empty, bus.req_rd_en}), 128'(0));
         step();
         bus.su_in_rd_en = 1'b0;
      end
      bus.req_empty    = 4'hF;
      bus.su_out_empty = 1'b0;
      settle();
      chk("rr_last_return", 128'(bus.rsp_wr_en), 128'(4'b0010));
      step();
      bus.su_out_empty = 1'b1;
      settle();
      chk("rr_inflight0", 128'(bus.inflight), 128'(0));

      // Return back-pressure: tags 1,0,3 with response FIFO 1 full for 10 cycles.
      issue_one(4'b0010, 4'b0010);
      issue_one(4'b0001, 4'b0001);
      issue_one(4'b1000, 4'b1000);
      settle();
      chk("bp_inflight3", 128'(bus.inflight), 128'(3));
      bus.rsp_full     = 4'b0010;
      bus.su_out_empty = 1'b0;
      for (int c = 0; c < 10; c++) begin
         settle();
         chk("bp_blocked", 128'({bus.su_out_rd_en, bus.rsp_wr_en}), 128'(0));
         step();
      end
      bus.rsp_full = 4'h0;
      settle();
      chk("bp_ret_first", 128'(bus.rsp_wr_en), 128'(4'b0010));
      step();
      chk("bp_ret_second", 128'(bus.rsp_wr_en), 128'(4'b0001));
      step();
      chk("bp_ret_third", 128'(bus.rsp_wr_en), 128'(4'b1000));
      step();
      bus.su_out_empty = 1'b1;
      settle();
      chk("bp_inflight0", 128'(bus.inflight), 128'(0));

      // Tag FIFO full stalls issue; first return re-enables it on the next cycle.
      for (int i = 0; i < 4; i++) begin
         bus.req_x[i] = mkv(100 * (i + 1), -(i + 1), i + 5);
         bus.req_a[i] = -(i + 11);
      end
      issue_one(4'hF, 4'b0001);
      issue_one(4'hF, 4'b0010);
      issue_one(4'hF, 4'b0100);
      issue_one(4'hF, 4'b1000);
      bus.req_empty = 4'h0;
      settle();
      chk("full_inflight4", 128'(bus.inflight), 128'(4));
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("full_stall", 128'(bus.req_rd_en), 128'(0));
         step();
      end
      bus.su_out_empty = 1'b0;
      settle();
      chk("full_ret", 128'(bus.rsp_wr_en), 128'(4'b0001));
      chk("full_still_stalled", 128'(bus.req_rd_en), 128'(0));
      step();
      bus.su_out_empty = 1'b1;
      settle();
      chk("full_inflight3", 128'(bus.inflight), 128'(3));
      chk("full_reissue", 128'(bus.req_rd_en), 128'(4'b0001));
      step();

      // Simultaneous tag push (id 0) and pop (head 1).
      bus.req_empty    = 4'hF;
      bus.su_in_rd_en  = 1'b1;
      bus.su_out_empty = 1'b0;
      settle();
      chk("pp_su_x", 128'(bus.su_x), 128'(mkv(100, -1, 5)));
      chk("pp_ret", 128'(bus.rsp_wr_en), 128'(4'b0010));
      step();
      bus.su_in_rd_en = 1'b0;
      settle();
      chk("pp_inflight3", 128'(bus.inflight), 128'(3));
      chk("pp_order_2", 128'(bus.rsp_wr_en), 128'(4'b0100));
      step();
      chk("pp_order_3", 128'(bus.rsp_wr_en), 128'(4'b1000));
      step();
      chk("pp_order_0", 128'(bus.rsp_wr_en), 128'(4'b0001));
      step();
      bus.su_out_empty = 1'b1;
      settle();
      chk("pp_inflight0", 128'(bus.inflight), 128'(0));

      // Reset while LOADED with three tags in flight.
      issue_one(4'hF, 4'b0010);
      issue_one(4'hF, 4'b0100);
      issue_one(4'hF, 4'b1000);
      bus.req_empty = 4'h0;
      settle();
      chk("mid_grant", 128'(bus.req_rd_en), 128'(4'b0001));
      step();
      chk("mid_loaded", 128'(bus.su_in_empty), 128'(0));
      chk("mid_inflight3", 128'(bus.inflight), 128'(3));
      reset = 1'b1;
      settle();
      chk("mid_rst_rd_en", 128'(bus.req_rd_en), 128'(0));
      step();
      reset = 1'b0;
      settle();
      chk("mid_su_in_empty", 128'(bus.su_in_empty), 128'(1));
      chk("mid_inflight0", 128'(bus.inflight), 128'(0));
      chk("mid_su_x", 128'(bus.su_x), 128'(0));
      chk("mid_next_grant", 128'(bus.req_rd_en), 128'(4'b0001));
      step();
      bus.req_empty = 4'hF;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
